// File: rtl/jk_down_counter_pkg.sv
// jk_down_counter_pkg
//   Shared constants and helpers for the JK down-counter slice:
//     - default WIDTH / MODULO values
//     - terminal_value(): the MODULO-1 value loaded on wrap and clamp
//     - max_modulo(): 2**WIDTH, the largest legal MODULO
//     - stage mode encodings used between the top and jk_down_stage
package jk_down_counter_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_MODULO = 10;

   // Stage steering modes.
   //   COUNT : J = K = t_in (toggle when every lower bit is 0 and en is high)
   //   LOAD  : J = target, K = ~target (parallel load of the clamped preset)
   //   WRAP  : J = target, K = ~target (target is MODULO-1)
   //   HOLD  : J = K = 0 (saturated at zero)
   localparam logic [1:0] MODE_COUNT = 2'd0;
   localparam logic [1:0] MODE_LOAD  = 2'd1;
   localparam logic [1:0] MODE_WRAP  = 2'd2;
   localparam logic [1:0] MODE_HOLD  = 2'd3;

   function automatic int terminal_value(input int modulo);
      return modulo - 1;
   endfunction

   function automatic int max_modulo(input int width);
      return 2 ** width;
   endfunction

endpackage

// File: rtl/jk_down_stage.sv
// jk_down_stage
//   One bit of the down counter: a JK flip-flop with asynchronous clear
//   (preset tied low) and a J/K steering mux selected by mode.
// Ports:
//   clk    in   clock, rising edge
//   clear  in   asynchronous active-high clear of q
//   mode   in   [1:0] COUNT / LOAD / WRAP / HOLD (see jk_down_counter_pkg)
//   t_in   in   toggle request from the lower bit (borrow chain)
//   target in   bit value for LOAD and WRAP modes
//   q      out  stage output
//   t_out  out  t_in & ~q, toggle request for the next higher bit
module jk_down_stage
   import jk_down_counter_pkg::*;
(
   input  logic       clk,
   input  logic       clear,
   input  logic [1:0] mode,
   input  logic       t_in,
   input  logic       target,
   output logic       q,
   output logic       t_out
);

   logic j;
   logic k;

   always_comb begin
      j = 1'b0;
      k = 1'b0;
      case (mode)
         MODE_COUNT: begin
            j = t_in;
            k = t_in;
         end
         MODE_LOAD, MODE_WRAP: begin
            j = target;
            k = ~target;
         end
         default: begin
            j = 1'b0;
            k = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

   // A bit below only passes the decrement up while it is 0 (it must borrow).
   assign t_out = t_in & ~q;

endmodule

// File: rtl/jk_down_counter.sv
// jk_down_counter
//   Synchronous presettable modulo-MODULO down counter built from WIDTH
//   JK flip-flop stages sharing one clock. Counts MODULO-1 down to 0 and
//   wraps; borrow is the cascade enable for a following counter.
//   Optional macro JK_DOWN_COUNTER_SATURATE_EN: stop at 0 instead of
//   wrapping, and pulse borrow for only the first enabled cycle at 0.
// Parameters:
//   WIDTH   counter width in bits
//   MODULO  count range, 2 .. 2**WIDTH
// Ports:
//   clk     in   clock, rising edge
//   clear   in   asynchronous active-high reset, forces q = 0
//   en      in   count enable
//   load    in   synchronous load of din (priority over en)
//   din     in   [WIDTH-1:0] preset, clamped to MODULO-1
//   q       out  [WIDTH-1:0] current count
//   zero    out  q == 0
//   borrow  out  en & ~load & (q == 0)
module jk_down_counter
   import jk_down_counter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int MODULO = DEF_MODULO
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             borrow
);

   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULO);
   localparam logic [WIDTH-1:0] TERM  = WIDTH'(terminal_value(MODULO));

   if (MODULO < 2 || MODULO > max_modulo(WIDTH)) begin : g_bad_modulo
      $error("jk_down_counter: MODULO must be in 2..2**WIDTH");
   end

   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] din_clamped;
   logic [WIDTH-1:0] target;
   logic [1:0]       mode;
   logic             out_of_range;
   logic             zero_en;
   logic             sat_hold;

   assign zero         = (q == '0);
   assign out_of_range = ({1'b0, q} >= MOD_W);
   assign din_clamped  = ({1'b0, din} >= MOD_W) ? TERM : din;
   assign target       = load ? din_clamped : TERM;

   // The borrow chain starts at en; its far end is en & (q == 0).
   assign t[0]    = en;
   assign zero_en = t[WIDTH];

`ifdef JK_DOWN_COUNTER_SATURATE_EN
   logic borrow_seen;

   assign sat_hold = 1'b1;
   assign borrow   = zero_en & ~load & ~borrow_seen;

   // Remembers that borrow already fired at this visit to zero.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         borrow_seen <= 1'b0;
      end else if (load) begin
         borrow_seen <= 1'b0;
      end else if (borrow) begin
         borrow_seen <= 1'b1;
      end
   end
`else
   assign sat_hold = 1'b0;
   assign borrow   = zero_en & ~load;
`endif

   always_comb begin
      mode = MODE_COUNT;
      if (load) begin
         mode = MODE_LOAD;
      end else if (en && zero) begin
         mode = sat_hold ? MODE_HOLD : MODE_WRAP;
      end else if (en && out_of_range) begin
         // Recover from an illegal power-up state.
         mode = MODE_WRAP;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      jk_down_stage u_stage (
         .clk    (clk),
         .clear  (clear),
         .mode   (mode),
         .t_in   (t[i]),
         .target (target[i]),
         .q      (q[i]),
         .t_out  (t[i+1])
      );
   end

endmodule

// File: tb/tb_jk_down_counter.sv
// tb_jk_down_counter
//   Directed bench for jk_down_counter (WIDTH=4, MODULO=10): reset, full
//   countdown, load priority and clamp, hold, asynchronous clear, a
//   two-digit cascade, and (with JK_DOWN_COUNTER_SATURATE_EN) saturation.
module tb_jk_down_counter;

   logic       clk = 1'b0;
   logic       clear;
   logic       en;
   logic       load;
   logic [3:0] din;
   logic [3:0] q;
   logic       zero;
   logic       borrow;

   logic       c_en;
   logic       c_load;
   logic [3:0] lo_q;
   logic [3:0] hi_q;
   logic       lo_zero;
   logic       hi_zero;
   logic       lo_borrow;
   logic       hi_borrow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   jk_down_counter #(.WIDTH(4), .MODULO(10)) dut (
      .clk(clk), .clear(clear), .en(en), .load(load), .din(din),
      .q(q), .zero(zero), .borrow(borrow)
   );

   jk_down_counter #(.WIDTH(4), .MODULO(10)) c_lo (
      .clk(clk), .clear(clear), .en(c_en), .load(c_load), .din(4'd0),
      .q(lo_q), .zero(lo_zero), .borrow(lo_borrow)
   );

   jk_down_counter #(.WIDTH(4), .MODULO(10)) c_hi (
      .clk(clk), .clear(clear), .en(lo_borrow), .load(c_load), .din(4'd0),
      .q(hi_q), .zero(hi_zero), .borrow(hi_borrow)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_q;
      int combined;
      int prev;
      int wraps;

      // Reset held with en=1: clock edges must be ignored.
      clear  = 1'b1;
      en     = 1'b1;
      load   = 1'b0;
      din    = 4'd0;
      c_en   = 1'b0;
      c_load = 1'b0;
      #1;
      check("reset_q_async", int'(q), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_q", int'(q), 0);
         check("reset_zero", int'(zero), 1);
      end
      check("reset_borrow", int'(borrow), 1);

`ifndef JK_DOWN_COUNTER_SATURATE_EN
      // Release: next edge wraps to 9.
      clear = 1'b0;
      #1;
      check("release_borrow_pre", int'(borrow), 1);
      step();
      check("release_wrap_q", int'(q), 9);
      check("release_borrow_post", int'(borrow), 0);
      check("release_zero_post", int'(zero), 0);

      // Full countdown from 9.
      load = 1'b1; en = 1'b0; din = 4'd9;
      step();
      check("load9_q", int'(q), 9);
      load = 1'b0; en = 1'b1;
      #1;
      for (int k = 1; k <= 10; k++) begin
         step();
         exp_q = (k <= 9) ? 9 - k : 9;
         check("count_q", int'(q), exp_q);
         check("count_zero", int'(zero), (exp_q == 0) ? 1 : 0);
         check("count_borrow", int'(borrow), (exp_q == 0) ? 1 : 0);
      end
`else
      clear = 1'b0;
`endif

      // Load has priority over en; out-of-range presets clamp to 9.
      load = 1'b1; en = 1'b1; din = 4'd0;
      #1;
      check("load_blocks_borrow", int'(borrow), 0);
      din = 4'd5;
      step();
      check("load5_q", int'(q), 5);
      din = 4'd13;
      step();
      check("load13_clamp", int'(q), 9);
      din = 4'd10;
      step();
      check("load10_clamp", int'(q), 9);
      din = 4'd15;
      step();
      check("load15_clamp", int'(q), 9);
      din = 4'd6;
      step();
      check("load6_q", int'(q), 6);

      // Hold.
      load = 1'b0; en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_q", int'(q), 6);
      end
      en = 1'b1;
      step();
      check("resume_q", int'(q), 5);

      // Asynchronous clear between edges.
      #2;
      clear = 1'b1;
      #1;
      check("async_clear_q", int'(q), 0);
      check("async_clear_zero", int'(zero), 1);
      clear = 1'b0;

`ifndef JK_DOWN_COUNTER_SATURATE_EN
      check("after_clear_borrow", int'(borrow), 1);
      step();
      check("after_clear_wrap", int'(q), 9);
      step();
      check("after_clear_count", int'(q), 8);

      // Two-digit cascade preloaded to 00.
      c_load = 1'b1;
      step();
      c_load = 1'b0;
      c_en   = 1'b1;
      #1;
      combined = int'(hi_q) * 10 + int'(lo_q);
      check("cascade_preload", combined, 0);
      prev  = combined;
      wraps = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         combined = int'(hi_q) * 10 + int'(lo_q);
         if (prev == 0 && combined == 99) wraps++;
         check("cascade_count", combined, (100 - k) % 100);
         prev = combined;
      end
      check("cascade_wraps", wraps, 1);
      c_en = 1'b0;
`else
      // Saturate: load 2 then count past zero.
      load = 1'b1; en = 1'b1; din = 4'd2;
      step();
      check("sat_load2", int'(q), 2);
      load = 1'b0;
      #1;
      for (int k = 1; k <= 5; k++) begin
         step();
         check("sat_q", int'(q), (k == 1) ? 1 : 0);
         check("sat_borrow", int'(borrow), (k == 2) ? 1 : 0);
      end
      load = 1'b1; din = 4'd3;
      step();
      check("sat_reload3", int'(q), 3);
      load = 1'b0;
      step();
      check("sat_resume", int'(q), 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
